// File: rtl/pq_sieve_reader.sv
// ---------------------------------------------------------------------------
// pq_sieve_reader
//
// Read side of the pq candidate FIFO. Pops one NUM_BITS-wide random candidate
// at a time and runs a bit-serial trial-division sieve against the 15 small
// odd primes 3..53. Survivors go out on a valid/ready stream to the primality
// tester; everything else is dropped. Saturating pass/reject counters are kept.
//
// Ports
//   aclk           in   1         clock, all logic on the rising edge
//   srst           in   1         synchronous reset, active-high
//   pq_fifo_din    in   NUM_BITS  FIFO read data, valid the cycle after rd_en
//   pq_fifo_empty  in   1         FIFO empty flag (sampled only in IDLE)
//   pq_fifo_rd_en  out  1         registered one-cycle pop strobe
//   cand_out       out  NUM_BITS  surviving candidate
//   cand_valid     out  1         cand_out valid, held until cand_ready
//   cand_ready     in   1         downstream accepts candidate
//   passed_cnt     out  CNT_W     candidates handed off (saturating)
//   rejected_cnt   out  CNT_W     candidates dropped by the sieve (saturating)
//   busy           out  1         high in every state except IDLE
//
// Handshake: a candidate transfers on the rising edge where cand_valid and
// cand_ready are both high. cand_valid never drops and cand_out never changes
// while waiting for cand_ready; cand_ready outside OUT is ignored.
// ---------------------------------------------------------------------------
module pq_sieve_reader #(
    parameter int NUM_BITS = 128,
    parameter int CNT_W    = 32
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic [NUM_BITS-1:0] pq_fifo_din,
    input  logic                pq_fifo_empty,
    output logic                pq_fifo_rd_en,
    output logic [NUM_BITS-1:0] cand_out,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [CNT_W-1:0]    passed_cnt,
    output logic [CNT_W-1:0]    rejected_cnt,
    output logic                busy
);

    localparam int NP  = 15;
    localparam int BCW = $clog2(NUM_BITS);

    // Sieve primes, 6 bits each, entry i at [6*i +: 6].
    localparam logic [NP*6-1:0] PRIMES = {
        6'd53, 6'd47, 6'd43, 6'd41, 6'd37, 6'd31, 6'd29, 6'd23,
        6'd19, 6'd17, 6'd13, 6'd11, 6'd7,  6'd5,  6'd3
    };

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_SIEVE  = 3'd3;
    localparam logic [2:0] S_DECIDE = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    localparam logic [NUM_BITS-1:0] VAL_TWO  = NUM_BITS'(2);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [BCW-1:0]      LAST_BIT = BCW'(NUM_BITS - 1);

    logic [2:0]          r_state;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_cand;
    logic [BCW-1:0]      r_bit_cnt;
    logic [5:0]          r_rem [NP];
    logic                r_rd_en;
    logic                r_valid;
    logic [CNT_W-1:0]    r_pass;
    logic [CNT_W-1:0]    r_rej;

    logic [6:0]          w_sum  [NP];
    logic [6:0]          w_prime[NP];
    logic [5:0]          w_rem_next [NP];
    logic                w_div_hit;
    logic                w_reject;

    // One remainder step per prime: shift in the next MSB-first bit and do a
    // single conditional subtract. Since r < p, 2r+1 < 2p, so one subtract
    // always brings the result back below p.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            w_prime[i]    = {1'b0, PRIMES[i*6 +: 6]};
            w_sum[i]      = {r_rem[i], r_shift[NUM_BITS-1]};
            w_rem_next[i] = (w_sum[i] >= w_prime[i]) ? 6'(w_sum[i] - w_prime[i])
                                                      : w_sum[i][5:0];
        end
    end

    // A zero remainder means divisible by that prime, which only disqualifies
    // the candidate when the candidate is not the prime itself.
    always_comb begin
        w_div_hit = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if ((r_rem[i] == 6'd0) && (r_cand != NUM_BITS'(PRIMES[i*6 +: 6])))
                w_div_hit = 1'b1;
        end
    end

    assign w_reject = (r_cand < VAL_TWO)
                    || (!r_cand[0] && (r_cand != VAL_TWO))
                    || w_div_hit;

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cand    <= '0;
            r_bit_cnt <= '0;
            r_rd_en   <= 1'b0;
            r_valid   <= 1'b0;
            r_pass    <= '0;
            r_rej     <= '0;
            for (int i = 0; i < NP; i++) r_rem[i] <= 6'd0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!pq_fifo_empty) begin
                        r_state <= S_READ;
                        r_rd_en <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift   <= pq_fifo_din;
                    r_cand    <= pq_fifo_din;
                    r_bit_cnt <= LAST_BIT;
                    for (int i = 0; i < NP; i++) r_rem[i] <= 6'd0;
                    r_state   <= S_SIEVE;
                end
                S_SIEVE: begin
                    for (int i = 0; i < NP; i++) r_rem[i] <= w_rem_next[i];
                    r_shift <= r_shift << 1;
                    if (r_bit_cnt == '0) r_state <= S_DECIDE;
                    else                 r_bit_cnt <= r_bit_cnt - 1'b1;
                end
                S_DECIDE: begin
                    if (w_reject) begin
                        if (r_rej != CNT_MAX) r_rej <= r_rej + 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (r_valid && cand_ready) begin
                        r_valid <= 1'b0;
                        if (r_pass != CNT_MAX) r_pass <= r_pass + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pq_fifo_rd_en = r_rd_en;
    assign cand_out      = r_cand;
    assign cand_valid    = r_valid;
    assign passed_cnt    = r_pass;
    assign rejected_cnt  = r_rej;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pq_sieve_reader.sv
// ---------------------------------------------------------------------------
// tb_pq_sieve_reader
//
// Directed bench for pq_sieve_reader with a small FIFO model (data appears
// the cycle after rd_en). Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pq_sieve_reader;

    localparam int NB = 128;
    localparam int CW = 32;

    logic          aclk = 1'b0;
    logic          srst = 1'b1;
    logic [NB-1:0] pq_fifo_din = '0;
    logic          pq_fifo_empty;
    logic          pq_fifo_rd_en;
    logic [NB-1:0] cand_out;
    logic          cand_valid;
    logic          cand_ready = 1'b1;
    logic [CW-1:0] passed_cnt;
    logic [CW-1:0] rejected_cnt;
    logic          busy;

    pq_sieve_reader #(.NUM_BITS(NB), .CNT_W(CW)) dut (
        .aclk          (aclk),
        .srst          (srst),
        .pq_fifo_din   (pq_fifo_din),
        .pq_fifo_empty (pq_fifo_empty),
        .pq_fifo_rd_en (pq_fifo_rd_en),
        .cand_out      (cand_out),
        .cand_valid    (cand_valid),
        .cand_ready    (cand_ready),
        .passed_cnt    (passed_cnt),
        .rejected_cnt  (rejected_cnt),
        .busy          (busy)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- FIFO model ----------------
    logic [NB-1:0] fifo_mem [16];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign pq_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge aclk) begin
        if (pq_fifo_rd_en && (wr_ptr != rd_ptr)) begin
            pq_fifo_din <= fifo_mem[rd_ptr % 16];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    int valid_cycles = 0;
    always @(negedge aclk) if (cand_valid === 1'b1) valid_cycles <= valid_cycles + 1;

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [NB-1:0] w);
        fifo_mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        srst = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        srst = 1'b0;
    endtask

    task automatic wait_rd(input string tag, output int c);
        logic found;
        found = 1'b0;
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge aclk);
            if (pq_fifo_rd_en === 1'b1) begin
                found = 1'b1;
                c = cyc;
                break;
            end
        end
        check(tag, NB'(found), NB'(1));
    endtask

    task automatic wait_valid(input string tag, output int c);
        logic found;
        found = 1'b0;
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge aclk);
            if (cand_valid === 1'b1) begin
                found = 1'b1;
                c = cyc;
                break;
            end
        end
        check(tag, NB'(found), NB'(1));
    endtask

    // ---------------- directed sequence ----------------
    logic [NB-1:0] mersenne;
    int c_rd, c_v, c1, c2, c3, vc0;
    logic rd_low, stable_ok;

    initial begin
        mersenne = {1'b0, {(NB-1){1'b1}}};

        // 1. reset held 3 cycles with FIFO non-empty
        srst = 1'b1;
        cand_ready = 1'b1;
        push(mersenne);
        rd_low = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            if (pq_fifo_rd_en !== 1'b0) rd_low = 1'b0;
        end
        check("rst_rd_en_low", NB'(rd_low), NB'(1));
        check("rst_cand_valid", NB'(cand_valid), NB'(0));
        check("rst_cand_out", cand_out, '0);
        check("rst_busy", NB'(busy), NB'(0));
        check("rst_passed", NB'(passed_cnt), NB'(0));
        check("rst_rejected", NB'(rejected_cnt), NB'(0));
        srst = 1'b0;

        // 2. Mersenne prime 2^127-1 passes with 131-cycle latency
        wait_rd("t2_rd_seen", c_rd);
        @(negedge aclk);
        check("t2_rd_one_cycle", NB'(pq_fifo_rd_en), NB'(0));
        check("t2_busy", NB'(busy), NB'(1));
        wait_valid("t2_valid_seen", c_v);
        check("t2_latency", NB'(c_v - c_rd), NB'(131));
        check("t2_cand_out", cand_out, mersenne);
        @(negedge aclk);
        check("t2_valid_drop", NB'(cand_valid), NB'(0));
        check("t2_passed", NB'(passed_cnt), NB'(1));

        // 3. 129, 1000, 1 are all rejected
        do_reset();
        vc0 = valid_cycles;
        push(NB'(129));
        push(NB'(1000));
        push(NB'(1));
        wait_rd("t3_rd1", c1);
        wait_rd("t3_rd2", c2);
        wait_rd("t3_rd3", c3);
        check("t3_gap12", NB'(c2 - c1 >= 132), NB'(1));
        check("t3_gap23", NB'(c3 - c2 >= 132), NB'(1));
        repeat (140) @(negedge aclk);
        check("t3_rejected", NB'(rejected_cnt), NB'(3));
        check("t3_passed", NB'(passed_cnt), NB'(0));
        check("t3_no_valid", NB'(valid_cycles - vc0), NB'(0));
        check("t3_idle", NB'(busy), NB'(0));

        // 4. 53 (equals a sieve prime) and 2 both pass
        do_reset();
        push(NB'(53));
        push(NB'(2));
        wait_valid("t4_valid1", c_v);
        check("t4_out53", cand_out, NB'(53));
        wait_valid("t4_valid2", c_v);
        check("t4_out2", cand_out, NB'(2));
        @(negedge aclk);
        check("t4_passed", NB'(passed_cnt), NB'(2));
        check("t4_rejected", NB'(rejected_cnt), NB'(0));

        // 5. backpressure: 97 held 20 cycles, no pop of 101 meanwhile
        do_reset();
        cand_ready = 1'b0;
        push(NB'(97));
        push(NB'(101));
        wait_valid("t5_valid", c_v);
        check("t5_out97", cand_out, NB'(97));
        stable_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (cand_valid !== 1'b1 || cand_out !== NB'(97) || pq_fifo_rd_en !== 1'b0 || busy !== 1'b1)
                stable_ok = 1'b0;
        end
        check("t5_held_stable", NB'(stable_ok), NB'(1));
        check("t5_passed_before", NB'(passed_cnt), NB'(0));
        cand_ready = 1'b1;
        @(negedge aclk);
        check("t5_valid_drop", NB'(cand_valid), NB'(0));
        check("t5_passed", NB'(passed_cnt), NB'(1));
        wait_rd("t5_next_pop", c_rd);
        wait_valid("t5_valid2", c_v);
        check("t5_out101", cand_out, NB'(101));
        @(negedge aclk);
        check("t5_passed2", NB'(passed_cnt), NB'(2));

        // 6. srst during SIEVE discards the candidate and clears counters
        push(NB'(103));
        wait_rd("t6_rd", c_rd);
        repeat (50) @(negedge aclk);
        check("t6_busy_sieve", NB'(busy), NB'(1));
        srst = 1'b1;
        @(negedge aclk);
        srst = 1'b0;
        check("t6_idle", NB'(busy), NB'(0));
        check("t6_passed_clr", NB'(passed_cnt), NB'(0));
        check("t6_valid_low", NB'(cand_valid), NB'(0));
        vc0 = valid_cycles;
        repeat (150) @(negedge aclk);
        check("t6_no_valid", NB'(valid_cycles - vc0), NB'(0));
        check("t6_rejected_clr", NB'(rejected_cnt), NB'(0));
        push(NB'(107));
        wait_valid("t6_valid_after", c_v);
        check("t6_out107", cand_out, NB'(107));
        @(negedge aclk);
        check("t6_passed", NB'(passed_cnt), NB'(1));

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
